pos_window_avg: RTL and testbench
=================================

Name: pos_window_avg

Overview:
- Downstream consumer of the position stage in the signal-processing chain.
- Takes the one-clock position-ready pulse with signed X/Y and sum S, and drops calibration events.
- Averages a programmable window of 2^k real events and presents registered means plus a one-clock ready pulse.
- Feeds the slow-FIFO packer and the LabVIEW readback registers.

Parameters:
DATA_WIDTH, 16, width of X/Y/S samples (2's complement for X/Y, unsigned for S)
MAX_LOG2, 8, largest window exponent; window N = 2^k, k <= MAX_LOG2
ACC_WIDTH, DATA_WIDTH+MAX_LOG2, accumulator width per channel

Ports:
clk  input  1  slow processing clock, 10 MHz
rst  input  1  synchronous active-high reset
run  input  1  enable; low holds block in IDLE
clr  input  1  restart current window, sync pulse
win_log2  input  4  window exponent k; values > MAX_LOG2 saturate to MAX_LOG2
in_valid  input  1  one-clock position-ready pulse
cal_flag  input  1  marks current event as calibration
x_in  input  DATA_WIDTH  signed X position
y_in  input  DATA_WIDTH  signed Y position
s_in  input  DATA_WIDTH  unsigned sum
x_avg  output  DATA_WIDTH  signed windowed mean X
y_avg  output  DATA_WIDTH  signed windowed mean Y
s_avg  output  DATA_WIDTH  unsigned windowed mean S
avg_rdy  output  1  one-clock pulse, means updated
win_cnt  output  MAX_LOG2+1  real events accumulated in current window
win_done_cnt  output  16  completed windows, wraps at 0xFFFF->0

Behaviour:
- Reset: every output 0; all accumulators 0; state IDLE.
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Accept condition: acc = in_valid & !cal_flag & state==ACCUM.
  - Calibration events (cal_flag=1) are ignored entirely.
- Window latch: k is latched from win_log2 on IDLE->ACCUM and at each window restart.
  - A change of win_log2 mid-window (compared with the latched k) clears the accumulators and win_cnt, latches the new k, and starts a new window.
  - An in_valid arriving in that same cycle is not accepted.
- States:
  - IDLE: accumulators cleared. run=1 -> ACCUM.
  - ACCUM: on acc, add x_in/y_in (sign-extended) and s_in (zero-extended) to ACC_WIDTH accumulators; win_cnt+1. When acc occurs with win_cnt == 2^k-1 -> DONE.
  - DONE (1 cycle):
    - x_avg = (accX + 2^(k-1)) >>> k, round half up, arithmetic shift. Same rule for y_avg; s_avg uses a logical shift.
    - For k=0, no rounding term: outputs equal the single sample.
    - Result truncated to DATA_WIDTH. This is exact: the mean is within input range.
    - avg_rdy=1; win_done_cnt+1; accumulators and win_cnt cleared. Next state ACCUM, or IDLE if run=0.
- Latency: avg_rdy asserts exactly 2 clk after the in_valid pulse that completes the window (1 cycle accumulate, 1 cycle DONE register).
  - x/y/s_avg are stable from that cycle until the next avg_rdy.
- in_valid during DONE is dropped. Upstream spacing is >= 1 µs, so no event is lost in practice.
- clr: clears accumulators and win_cnt, stays or returns to ACCUM. Outputs keep their last means; win_done_cnt is not cleared. clr has priority over acc in the same cycle.
- run falling in ACCUM: -> IDLE, partial window discarded, outputs held.
- rst mid-window: everything returns to the reset values above.
- Overflow: none possible. ACC_WIDTH covers 2^MAX_LOG2 full-scale samples of either sign.

Optional Feature:
- Macro: POS_WINDOW_MINMAX_EN.
- Defined:
  - Adds outputs x_min, x_max, y_min, y_max (DATA_WIDTH, signed), tracked over accepted samples of the current window.
  - Registered in the DONE cycle alongside the means and valid with avg_rdy.
  - Trackers are re-seeded by the first accepted sample of each window.
  - Reset value 0.
- Undefined: ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- k=2, run=1, four events X=100,102,104,106, Y=-10,-12,-14,-16, S=1000 each -> avg_rdy 2 clk after 4th pulse; x_avg=103, y_avg=-13, s_avg=1000; win_done_cnt=1.
- k=3, eight events with the 3rd and 6th having cal_flag=1 -> those two are ignored; avg_rdy only after 8 real events; win_cnt steps 0..7 then 0.
- Rounding, k=1: X=1,2 -> x_avg=2; X=-1,-2 -> x_avg=-1; X=-32768,-32768 -> -32768; X=32767,32767 -> 32767.
- Change win_log2 2->1 after 3 accepted events -> win_cnt=0, no avg_rdy; next 2 events -> avg_rdy with their mean.
- clr coincident with in_valid, then run dropped after 1 event, then rst mid-window -> sample not accepted; IDLE discards the partial window with outputs held; rst zeroes all outputs and counters.
- With POS_WINDOW_MINMAX_EN, k=2, X=5,-7,3,9 -> x_min=-7, x_max=9 at avg_rdy; next window X=1,1,1,1 -> x_min=x_max=1.

Source files
------------

// File: rtl/pos_window_avg_if.sv
// Sample/result bus between the position stage and the window averager.
// POS_WINDOW_MINMAX_EN adds the per-window min/max result signals.
interface pos_window_avg_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                         in_valid;
  logic                         cal_flag;
  logic signed [DATA_WIDTH-1:0] x_in;
  logic signed [DATA_WIDTH-1:0] y_in;
  logic        [DATA_WIDTH-1:0] s_in;
  logic signed [DATA_WIDTH-1:0] x_avg;
  logic signed [DATA_WIDTH-1:0] y_avg;
  logic        [DATA_WIDTH-1:0] s_avg;
  logic                         avg_rdy;
`ifdef POS_WINDOW_MINMAX_EN
  logic signed [DATA_WIDTH-1:0] x_min;
  logic signed [DATA_WIDTH-1:0] x_max;
  logic signed [DATA_WIDTH-1:0] y_min;
  logic signed [DATA_WIDTH-1:0] y_max;

  modport master (output in_valid, cal_flag, x_in, y_in, s_in,
                  input  x_avg, y_avg, s_avg, avg_rdy, x_min, x_max, y_min, y_max);
  modport slave  (input  in_valid, cal_flag, x_in, y_in, s_in,
                  output x_avg, y_avg, s_avg, avg_rdy, x_min, x_max, y_min, y_max);
`else
  modport master (output in_valid, cal_flag, x_in, y_in, s_in,
                  input  x_avg, y_avg, s_avg, avg_rdy);
  modport slave  (input  in_valid, cal_flag, x_in, y_in, s_in,
                  output x_avg, y_avg, s_avg, avg_rdy);
`endif
endinterface

// File: rtl/pos_window_avg.sv
// Windowed (2^k events) mean of X/Y/S position samples, calibration events dropped.
// Optional min/max tracking enabled by POS_WINDOW_MINMAX_EN.
module pos_window_avg #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_LOG2   = 8,
  parameter int unsigned ACC_WIDTH  = DATA_WIDTH + MAX_LOG2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                clr,
  input  logic [3:0]          win_log2,
  pos_window_avg_if.slave     bus,
  output logic [MAX_LOG2:0]   win_cnt,
  output logic [15:0]         win_done_cnt
);
  localparam int unsigned CW  = MAX_LOG2 + 1;
  localparam int unsigned EXT = ACC_WIDTH - DATA_WIDTH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [3:0]                  k_q, k_d;
  logic signed [ACC_WIDTH-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic        [ACC_WIDTH-1:0] acc_s_q, acc_s_d;
  logic [CW-1:0]               win_cnt_q, win_cnt_d;
  logic [15:0]                 done_cnt_q, done_cnt_d;
  logic signed [DATA_WIDTH-1:0] x_avg_q, x_avg_d, y_avg_q, y_avg_d;
  logic        [DATA_WIDTH-1:0] s_avg_q, s_avg_d;
  logic                         avg_rdy_q, avg_rdy_d;
`ifdef POS_WINDOW_MINMAX_EN
  logic signed [DATA_WIDTH-1:0] trk_xmin_q, trk_xmin_d, trk_xmax_q, trk_xmax_d;
  logic signed [DATA_WIDTH-1:0] trk_ymin_q, trk_ymin_d, trk_ymax_q, trk_ymax_d;
  logic signed [DATA_WIDTH-1:0] x_min_q, x_min_d, x_max_q, x_max_d;
  logic signed [DATA_WIDTH-1:0] y_min_q, y_min_d, y_max_q, y_max_d;
`endif

  logic [3:0]                  k_sat;
  logic [CW-1:0]               win_max;
  logic        [ACC_WIDTH-1:0] rnd;
  logic signed [ACC_WIDTH-1:0] x_ext, y_ext, x_rnd, y_rnd;
  logic        [ACC_WIDTH-1:0] s_ext, s_rnd;
  logic                        acc;

  // Window exponent saturation, last-sample index, rounding term and sample extension
  always_comb begin
    k_sat   = (win_log2 > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : win_log2;
    win_max = (CW'(1) << k_q) - CW'(1);
    rnd     = (k_q == 4'd0) ? '0 : (ACC_WIDTH'(1) << (k_q - 4'd1));
    x_ext   = {{EXT{bus.x_in[DATA_WIDTH-1]}}, bus.x_in};
    y_ext   = {{EXT{bus.y_in[DATA_WIDTH-1]}}, bus.y_in};
    s_ext   = {{EXT{1'b0}}, bus.s_in};
    x_rnd   = acc_x_q + $signed(rnd);
    y_rnd   = acc_y_q + $signed(rnd);
    s_rnd   = acc_s_q + rnd;
    acc     = bus.in_valid && !bus.cal_flag;
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    acc_x_d    = acc_x_q;
    acc_y_d    = acc_y_q;
    acc_s_d    = acc_s_q;
    win_cnt_d  = win_cnt_q;
    done_cnt_d = done_cnt_q;
    x_avg_d    = x_avg_q;
    y_avg_d    = y_avg_q;
    s_avg_d    = s_avg_q;
    avg_rdy_d  = 1'b0;
`ifdef POS_WINDOW_MINMAX_EN
    trk_xmin_d = trk_xmin_q;
    trk_xmax_d = trk_xmax_q;
    trk_ymin_d = trk_ymin_q;
    trk_ymax_d = trk_ymax_q;
    x_min_d    = x_min_q;
    x_max_d    = x_max_q;
    y_min_d    = y_min_q;
    y_max_d    = y_max_q;
`endif
    case (state_q)
      IDLE: begin
        acc_x_d   = '0;
        acc_y_d   = '0;
        acc_s_d   = '0;
        win_cnt_d = '0;
        if (run) begin
          state_d = ACCUM;
          k_d     = k_sat;
        end
      end
      ACCUM: begin
        if (!run) begin
          state_d   = IDLE;
          acc_x_d   = '0;
          acc_y_d   = '0;
          acc_s_d   = '0;
          win_cnt_d = '0;
        end else if (clr || (k_sat != k_q)) begin
          // Window restart: the event in this cycle is not taken
          k_d       = k_sat;
          acc_x_d   = '0;
          acc_y_d   = '0;
          acc_s_d   = '0;
          win_cnt_d = '0;
        end else if (acc) begin
          acc_x_d   = acc_x_q + x_ext;
          acc_y_d   = acc_y_q + y_ext;
          acc_s_d   = acc_s_q + s_ext;
          win_cnt_d = win_cnt_q + CW'(1);
`ifdef POS_WINDOW_MINMAX_EN
          if (win_cnt_q == '0) begin
            trk_xmin_d = bus.x_in;
            trk_xmax_d = bus.x_in;
            trk_ymin_d = bus.y_in;
            trk_ymax_d = bus.y_in;
          end else begin
            if (bus.x_in < trk_xmin_q) trk_xmin_d = bus.x_in;
            if (bus.x_in > trk_xmax_q) trk_xmax_d = bus.x_in;
            if (bus.y_in < trk_ymin_q) trk_ymin_d = bus.y_in;
            if (bus.y_in > trk_ymax_q) trk_ymax_d = bus.y_in;
          end
`endif
          if (win_cnt_q == win_max) state_d = DONE;
        end
      end
      DONE: begin
        x_avg_d    = DATA_WIDTH'(x_rnd >>> k_q);
        y_avg_d    = DATA_WIDTH'(y_rnd >>> k_q);
        s_avg_d    = DATA_WIDTH'(s_rnd >> k_q);
        avg_rdy_d  = 1'b1;
        done_cnt_d = done_cnt_q + 16'd1;
        acc_x_d    = '0;
        acc_y_d    = '0;
        acc_s_d    = '0;
        win_cnt_d  = '0;
        k_d        = k_sat;
`ifdef POS_WINDOW_MINMAX_EN
        x_min_d    = trk_xmin_q;
        x_max_d    = trk_xmax_q;
        y_min_d    = trk_ymin_q;
        y_max_d    = trk_ymax_q;
`endif
        state_d    = run ? ACCUM : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      acc_s_q    <= '0;
      win_cnt_q  <= '0;
      done_cnt_q <= '0;
      x_avg_q    <= '0;
      y_avg_q    <= '0;
      s_avg_q    <= '0;
      avg_rdy_q  <= 1'b0;
`ifdef POS_WINDOW_MINMAX_EN
      trk_xmin_q <= '0;
      trk_xmax_q <= '0;
      trk_ymin_q <= '0;
      trk_ymax_q <= '0;
      x_min_q    <= '0;
      x_max_q    <= '0;
      y_min_q    <= '0;
      y_max_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      acc_s_q    <= acc_s_d;
      win_cnt_q  <= win_cnt_d;
      done_cnt_q <= done_cnt_d;
      x_avg_q    <= x_avg_d;
      y_avg_q    <= y_avg_d;
      s_avg_q    <= s_avg_d;
      avg_rdy_q  <= avg_rdy_d;
`ifdef POS_WINDOW_MINMAX_EN
      trk_xmin_q <= trk_xmin_d;
      trk_xmax_q <= trk_xmax_d;
      trk_ymin_q <= trk_ymin_d;
      trk_ymax_q <= trk_ymax_d;
      x_min_q    <= x_min_d;
      x_max_q    <= x_max_d;
      y_min_q    <= y_min_d;
      y_max_q    <= y_max_d;
`endif
    end
  end

  assign bus.x_avg    = x_avg_q;
  assign bus.y_avg    = y_avg_q;
  assign bus.s_avg    = s_avg_q;
  assign bus.avg_rdy  = avg_rdy_q;
  assign win_cnt      = win_cnt_q;
  assign win_done_cnt = done_cnt_q;
`ifdef POS_WINDOW_MINMAX_EN
  assign bus.x_min    = x_min_q;
  assign bus.x_max    = x_max_q;
  assign bus.y_min    = y_min_q;
  assign bus.y_max    = y_max_q;
`endif
endmodule

// File: tb/tb_pos_window_avg.sv
// Scoreboard bench for pos_window_avg: directed and random windows vs a mean-of-samples model.
module tb_pos_window_avg;
  localparam int unsigned DW = 16;
  localparam int unsigned ML = 8;

  logic          clk = 1'b0;
  logic          rst, run, clr;
  logic [3:0]    win_log2;
  logic [ML:0]   win_cnt;
  logic [15:0]   win_done_cnt;

  pos_window_avg_if #(.DATA_WIDTH(DW)) bus ();

  pos_window_avg #(.DATA_WIDTH(DW), .MAX_LOG2(ML)) dut (
    .clk(clk), .rst(rst), .run(run), .clr(clr), .win_log2(win_log2),
    .bus(bus.slave), .win_cnt(win_cnt), .win_done_cnt(win_done_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     x, y, s, dcnt;
    int     xmin, xmax, ymin, ymax;
    longint cyc;
  } exp_t;

  exp_t   sb[$];
  exp_t   last;
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  int mx[$], my[$], ms[$];
  int mk;
  int mdone;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int sat(int k);
    return (k > int'(ML)) ? int'(ML) : k;
  endfunction

  // Round-half-up mean of a list of integers
  function automatic int mean(int q[$]);
    longint sum = 0;
    foreach (q[i]) sum += q[i];
    return int'($rtoi($floor(real'(sum) / real'(q.size()) + 0.5)));
  endfunction

  function automatic int qmin(int q[$]);
    int m = q[0];
    foreach (q[i]) if (q[i] < m) m = q[i];
    return m;
  endfunction

  function automatic int qmax(int q[$]);
    int m = q[0];
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  function automatic void model_clear();
    mx.delete(); my.delete(); ms.delete();
  endfunction

  // Adds a real event to the model window; returns 1 when the window completes
  function automatic bit model_accept(int x, int y, int s, longint c);
    exp_t e;
    mx.push_back(x); my.push_back(y); ms.push_back(s);
    if (mx.size() < (1 << mk)) return 1'b0;
    e.x = mean(mx); e.y = mean(my); e.s = mean(ms);
    e.xmin = qmin(mx); e.xmax = qmax(mx); e.ymin = qmin(my); e.ymax = qmax(my);
    mdone = (mdone + 1) % 65536;
    e.dcnt = mdone;
    e.cyc  = c + 2;
    sb.push_back(e);
    last = e;
    model_clear();
    return 1'b1;
  endfunction

  task automatic send(input int x, input int y, input int s, input bit cal, output bit done);
    longint c;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.cal_flag = cal;
    bus.x_in = DW'(x); bus.y_in = DW'(y); bus.s_in = DW'(s);
    c = cyc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.cal_flag = 1'b0;
    done = 1'b0;
    if (!cal) done = model_accept(x, y, s, c);
    if (!done) check("win_cnt", longint'(win_cnt), longint'(mx.size()));
  endtask

  task automatic set_k(input int k);
    @(posedge clk); #1;
    win_log2 = 4'(k);
    repeat (2) @(posedge clk);
    #1;
    if (sat(k) != mk) model_clear();
    mk = sat(k);
  endtask

  task automatic rand_sample(output int x, output int y, output int s);
    logic [15:0] r;
    r = 16'($urandom); x = int'($signed(r));
    r = 16'($urandom); y = int'($signed(r));
    r = 16'($urandom); s = int'(r);
  endtask

  task automatic check_held(string tag);
    check({tag, "_x_avg"}, longint'($signed(bus.x_avg)), longint'(last.x));
    check({tag, "_y_avg"}, longint'($signed(bus.y_avg)), longint'(last.y));
    check({tag, "_s_avg"}, longint'(bus.s_avg), longint'(last.s));
    check({tag, "_done_cnt"}, longint'(win_done_cnt), longint'(mdone));
  endtask

  // Monitor: every avg_rdy must match the oldest expected window result
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.avg_rdy) begin
      if (sb.size() == 0) begin
        check("unexpected_avg_rdy", 1, 0);
      end else begin
        e = sb.pop_front();
        check("rdy_cycle", cyc, e.cyc);
        check("x_avg", longint'($signed(bus.x_avg)), longint'(e.x));
        check("y_avg", longint'($signed(bus.y_avg)), longint'(e.y));
        check("s_avg", longint'(bus.s_avg), longint'(e.s));
        check("win_done_cnt", longint'(win_done_cnt), longint'(e.dcnt));
`ifdef POS_WINDOW_MINMAX_EN
        check("x_min", longint'($signed(bus.x_min)), longint'(e.xmin));
        check("x_max", longint'($signed(bus.x_max)), longint'(e.xmax));
        check("y_min", longint'($signed(bus.y_min)), longint'(e.ymin));
        check("y_max", longint'($signed(bus.y_max)), longint'(e.ymax));
`endif
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    int x, y, s, n;
    int xs[4];
    rst = 1'b1; run = 1'b0; clr = 1'b0; win_log2 = 4'd0;
    bus.in_valid = 1'b0; bus.cal_flag = 1'b0;
    bus.x_in = '0; bus.y_in = '0; bus.s_in = '0;
    last = '{default: 0};
    mdone = 0; mk = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_held("reset");
    check("reset_avg_rdy", longint'(bus.avg_rdy), 0);
    check("reset_win_cnt", longint'(win_cnt), 0);

    // k=2 basic window
    win_log2 = 4'd2; run = 1'b1;
    repeat (2) @(posedge clk);
    #1 mk = 2;
    for (int i = 0; i < 4; i++) send(100 + 2*i, -10 - 2*i, 1000, 1'b0, done);
    check("basic_done", longint'(done), 1);

    // k=3 with calibration events at positions 3 and 6
    set_k(3);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      send(i * 7 - 20, 3 - i, 500 + i, (i == 2) || (i == 5), done);
      if (done) n++;
    end
    check("cal_windows", n, 1);

    // k=1 rounding and range boundaries
    set_k(1);
    send(1, 1, 1, 1'b0, done);            send(2, 2, 2, 1'b0, done);
    send(-1, -1, 0, 1'b0, done);          send(-2, -2, 1, 1'b0, done);
    send(-32768, -32768, 65535, 1'b0, done); send(-32768, -32768, 65535, 1'b0, done);
    send(32767, 32767, 65535, 1'b0, done);   send(32767, 32767, 65534, 1'b0, done);

    // window change mid-window discards the partial window
    set_k(2);
    for (int i = 0; i < 3; i++) send(50 + i, -50 - i, 10 * i, 1'b0, done);
    set_k(1);
    check("kchange_win_cnt", longint'(win_cnt), 0);
    send(7, -3, 9, 1'b0, done); send(8, -6, 12, 1'b0, done);
    check("kchange_done", longint'(done), 1);

    // clr coincident with in_valid: sample dropped, window restarted
    send(11, 11, 11, 1'b0, done);
    @(posedge clk); #1;
    clr = 1'b1; bus.in_valid = 1'b1; bus.x_in = DW'(30000); bus.y_in = '0; bus.s_in = '0;
    @(posedge clk); #1;
    clr = 1'b0; bus.in_valid = 1'b0;
    model_clear(); mk = sat(int'(win_log2));
    check("clr_win_cnt", longint'(win_cnt), 0);
    check_held("clr_hold");

    // run drop after one event: partial window discarded, outputs held
    send(-400, 400, 4000, 1'b0, done);
    run = 1'b0;
    repeat (3) @(posedge clk);
    #1 model_clear();
    check("idle_win_cnt", longint'(win_cnt), 0);
    check_held("idle_hold");
    run = 1'b1;
    repeat (2) @(posedge clk);
    #1 mk = sat(int'(win_log2));
    send(1, 2, 3, 1'b0, done); send(5, 6, 7, 1'b0, done);

    // synchronous reset mid-window
    send(999, 999, 999, 1'b0, done);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear(); mdone = 0; last = '{default: 0};
    check_held("rst_mid");
    check("rst_mid_win_cnt", longint'(win_cnt), 0);
    repeat (2) @(posedge clk);
    #1 mk = sat(int'(win_log2));

    // min/max windows
    set_k(2);
    xs = '{5, -7, 3, 9};
    for (int i = 0; i < 4; i++) send(xs[i], -xs[i], 20, 1'b0, done);
    for (int i = 0; i < 4; i++) send(1, 1, 1, 1'b0, done);

    // saturated exponent: 256 full-scale events
    set_k(15);
    for (int i = 0; i < 256; i++)
      send((i % 2) ? 32767 : 32766, -32768, 65535, 1'b0, done);
    check("sat_done", longint'(done), 1);

    // random windows with random calibration events
    for (int w = 0; w < 30; w++) begin
      set_k(int'($urandom_range(0, 4)));
      done = 1'b0;
      for (int j = 0; j < 200 && !done; j++) begin
        rand_sample(x, y, s);
        send(x, y, s, ($urandom_range(0, 4) == 0), done);
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      check("rand_window_done", longint'(done), 1);
    end

    repeat (10) @(posedge clk);
    #1 check("scoreboard_drained", longint'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
